bird_datapath: RTL and testbench

Position, animation and pixel-plot datapath for the duck. It sits directly downstream of the bird control FSM: it consumes the 4-bit `STATE` code and, in return, produces `doneDrawing` and `flying`. It also drives the VGA adapter's plot interface and publishes the bird's box position to the hit-detection logic.

---
 rtl/bird_pkg.sv | 43 ++++
 rtl/bird_sprite_rom.sv | 36 +++
 rtl/bird_datapath.sv | 223 ++++++++++++++++++++++
 tb/tb_bird_datapath.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bird_pkg.sv
// Shared definitions for the duck datapath and its control FSM.
// Holds the 4-bit state codes, the fall/rise animation enum and the
// screen dimensions so both sides of the interface agree on them.
package bird_pkg;

    // State codes driven by the bird control FSM
    localparam logic [3:0] ST_HOLD       = 4'h0;
    localparam logic [3:0] ST_CLEAR      = 4'h1;
    localparam logic [3:0] ST_UP_LEFT    = 4'h2;
    localparam logic [3:0] ST_UP_RIGHT   = 4'h3;
    localparam logic [3:0] ST_PREHOLD    = 4'h4;
    localparam logic [3:0] ST_DRAW       = 4'h5;
    localparam logic [3:0] ST_DOWN_RIGHT = 4'h6;
    localparam logic [3:0] ST_DOWN_LEFT  = 4'h7;
    localparam logic [3:0] ST_SHOT       = 4'h8;
    localparam logic [3:0] ST_ESCAPE     = 4'h9;
    localparam logic [3:0] ST_NEW        = 4'hA;

    // Which off-screen animation, if any, the bird is currently in
    typedef enum logic [1:0] {
        ANIM_NONE = 2'd0,
        ANIM_FALL = 2'd1,
        ANIM_RISE = 2'd2
    } anim_t;

    // Screen dimensions of the VGA plot area
    localparam int X_MAX = 160;
    localparam int Y_MAX = 120;

    // True for every code the datapath acts on; anything else freezes it
    function automatic logic is_known_state(input logic [3:0] s);
        logic known;
        known = 1'b0;
        case (s)
            ST_HOLD, ST_CLEAR, ST_UP_LEFT, ST_UP_RIGHT, ST_PREHOLD,
            ST_DRAW, ST_DOWN_RIGHT, ST_DOWN_LEFT, ST_SHOT, ST_ESCAPE,
            ST_NEW: known = 1'b1;
            default: known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/bird_sprite_rom.sv
// 8x8 duck sprite lookup, one 3-bit colour code per pixel in raster order.
// Only built when BIRD_SPRITE_EN is defined; code 3'b000 means transparent.
// The lookup is combinational; the datapath registers it together with the
// pixel coordinates so the colour lines up with the plot strobe.
module bird_sprite_rom
    import bird_pkg::*;
(
    input  logic [6:0] addr_i,
    output logic [2:0] data_o
);

    logic [23:0] rowBits;
    logic [2:0]  row;
    logic [2:0]  col;

    // Pick the row pattern, then slice out the addressed pixel
    always_comb begin
        row = addr_i[5:3];
        col = addr_i[2:0];
        case (row)
            3'd0: rowBits = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd6, 3'd0};
            3'd1: rowBits = {3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd7, 3'd6, 3'd4};
            3'd2: rowBits = {3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd6, 3'd6, 3'd0};
            3'd3: rowBits = {3'd6, 3'd0, 3'd0, 3'd6, 3'd6, 3'd6, 3'd0, 3'd0};
            3'd4: rowBits = {3'd6, 3'd6, 3'd6, 3'd2, 3'd2, 3'd6, 3'd6, 3'd0};
            3'd5: rowBits = {3'd0, 3'd6, 3'd2, 3'd2, 3'd2, 3'd6, 3'd6, 3'd0};
            3'd6: rowBits = {3'd0, 3'd0, 3'd6, 3'd6, 3'd6, 3'd6, 3'd0, 3'd0};
            default: rowBits = {3'd0, 3'd0, 3'd4, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0};
        endcase
        data_o = rowBits[{col, 1'b0} + {2'b00, col} +: 3];
        if (addr_i[6]) begin
            data_o = 3'b000;
        end
    end

endmodule

// File: rtl/bird_datapath.sv
// Duck position, fall/rise animation and pixel sweep datapath.
// Consumes the FSM state code, returns doneDrawing/flying, drives the VGA
// plot interface and publishes the bird box position for hit detection.
// Optional feature: define BIRD_SPRITE_EN to colour DRAW pixels from the
// sprite ROM instead of a single solid colour.
module bird_datapath
    import bird_pkg::*;
#(
    parameter int         SPR_W       = 8,
    parameter int         SPR_H       = 8,
    parameter int         X_MAX       = bird_pkg::X_MAX,
    parameter int         Y_MAX       = bird_pkg::Y_MAX,
    parameter int         STEP        = 1,
    parameter int         FALL_STEP   = 4,
    parameter int         ESC_STEP    = 4,
    parameter int         START_X     = 76,
    parameter int         START_Y     = 100,
    parameter logic [2:0] BG_COLOUR   = 3'b011,
    parameter logic [2:0] BIRD_COLOUR = 3'b110
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] STATE,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       plot,
    output logic       doneDrawing,
    output logic       flying,
    output logic [7:0] bird_x,
    output logic [6:0] bird_y
);

    localparam int N  = SPR_W * SPR_H;
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0] N_C       = CW'(N);
    localparam logic [CW-1:0] SPR_W_C   = CW'(SPR_W);
    localparam logic [8:0]    X_LIM_W   = 9'(X_MAX - SPR_W);
    localparam logic [7:0]    Y_FLOOR_W = 8'(Y_MAX - SPR_H);
    localparam logic [6:0]    Y_FLOOR   = 7'(Y_MAX - SPR_H);

    logic [7:0]    birdXQ, birdXD;
    logic [6:0]    birdYQ, birdYD;
    anim_t         animQ, animD;
    logic [CW-1:0] cntQ, cntD;
    logic [3:0]    prevStateQ;
    logic [7:0]    xOutQ, xOutD;
    logic [6:0]    yOutQ, yOutD;
    logic [2:0]    colourQ, colourD;
    logic          plotQ, plotD;

    logic          knownState;
    logic          stateChanged;
    logic          inSweep;
    logic          emitPixel;
    logic [CW-1:0] pixCol;
    logic [CW-1:0] pixRow;
    logic [2:0]    drawColour;

    logic [8:0]    xRight, xLeft;
    logic [7:0]    yDown, yUp, yFall, yEsc;
    logic [7:0]    xRightSat, xLeftSat;
    logic [6:0]    yDownSat, yUpSat, yFallSat, yEscSat;

    // Saturating moves: every sum/difference is one bit wider than the
    // register, so overflow shows up as a compare and borrow as the top bit
    always_comb begin
        xRight = {1'b0, birdXQ} + 9'(STEP);
        xLeft  = {1'b0, birdXQ} - 9'(STEP);
        yDown  = {1'b0, birdYQ} + 8'(STEP);
        yUp    = {1'b0, birdYQ} - 8'(STEP);
        yFall  = {1'b0, birdYQ} + 8'(FALL_STEP);
        yEsc   = {1'b0, birdYQ} - 8'(ESC_STEP);

        xRightSat = (xRight > X_LIM_W)  ? X_LIM_W[7:0] : xRight[7:0];
        xLeftSat  = xLeft[8]            ? 8'd0         : xLeft[7:0];
        yDownSat  = (yDown > Y_FLOOR_W) ? Y_FLOOR      : yDown[6:0];
        yUpSat    = yUp[7]              ? 7'd0         : yUp[6:0];
        yFallSat  = (yFall > Y_FLOOR_W) ? Y_FLOOR      : yFall[6:0];
        yEscSat   = yEsc[7]             ? 7'd0         : yEsc[6:0];
    end

    // Next position and animation for whichever state the FSM is in;
    // states that do not move the bird leave it where it is
    always_comb begin
        birdXD = birdXQ;
        birdYD = birdYQ;
        animD  = animQ;
        case (STATE)
            ST_UP_RIGHT: begin
                birdXD = xRightSat;
                birdYD = yUpSat;
            end
            ST_UP_LEFT: begin
                birdXD = xLeftSat;
                birdYD = yUpSat;
            end
            ST_DOWN_RIGHT: begin
                birdXD = xRightSat;
                birdYD = yDownSat;
            end
            ST_DOWN_LEFT: begin
                birdXD = xLeftSat;
                birdYD = yDownSat;
            end
            ST_SHOT: begin
                birdYD = yFallSat;
                animD  = ANIM_FALL;
            end
            ST_ESCAPE: begin
                birdYD = yEscSat;
                animD  = ANIM_RISE;
            end
            ST_NEW: begin
                birdXD = 8'(START_X);
                birdYD = 7'(START_Y);
                animD  = ANIM_NONE;
            end
            default: begin
                birdXD = birdXQ;
                birdYD = birdYQ;
                animD  = animQ;
            end
        endcase
    end

`ifdef BIRD_SPRITE_EN
    logic [2:0] romData;

    bird_sprite_rom u_sprite_rom (
        .addr_i (7'(cntQ)),
        .data_o (romData)
    );

    // Transparent sprite pixels repaint the background colour
    always_comb begin
        drawColour = (romData == 3'b000) ? BG_COLOUR : romData;
    end
`else
    // Without the sprite ROM the duck is one solid block
    always_comb begin
        drawColour = BIRD_COLOUR;
    end
`endif

    // Pixel sweep: the counter restarts on any state change (this is what
    // lets CLEAR go straight into DRAW), then walks the box in raster order
    // and parks at N so the sweep cannot plot a second time
    always_comb begin
        knownState   = is_known_state(STATE);
        stateChanged = (STATE != prevStateQ);
        inSweep      = (STATE == ST_CLEAR) || (STATE == ST_DRAW);
        emitPixel    = inSweep && !stateChanged && (cntQ < N_C);
        pixCol       = cntQ % SPR_W_C;
        pixRow       = cntQ / SPR_W_C;

        cntD    = cntQ;
        plotD   = emitPixel;
        xOutD   = xOutQ;
        yOutD   = yOutQ;
        colourD = colourQ;
        if (stateChanged) begin
            cntD = '0;
        end else if (emitPixel) begin
            cntD = cntQ + 1'b1;
        end
        if (emitPixel) begin
            xOutD   = birdXQ + 8'(pixCol);
            yOutD   = birdYQ + 7'(pixRow);
            colourD = (STATE == ST_DRAW) ? drawColour : BG_COLOUR;
        end
    end

    // All state lives here; an unknown state code freezes every register
    // and only drops the plot strobe so no stray pixel is written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            birdXQ     <= 8'(START_X);
            birdYQ     <= 7'(START_Y);
            animQ      <= ANIM_NONE;
            cntQ       <= '0;
            prevStateQ <= ST_PREHOLD;
            xOutQ      <= '0;
            yOutQ      <= '0;
            colourQ    <= '0;
            plotQ      <= 1'b0;
        end else if (knownState) begin
            birdXQ     <= birdXD;
            birdYQ     <= birdYD;
            animQ      <= animD;
            cntQ       <= cntD;
            prevStateQ <= STATE;
            xOutQ      <= xOutD;
            yOutQ      <= yOutD;
            colourQ    <= colourD;
            plotQ      <= plotD;
        end else begin
            plotQ      <= 1'b0;
        end
    end

    // Status back to the FSM, computed from the pre-update position so the
    // visit that finds the bird at the floor/ceiling reports it as landed
    always_comb begin
        doneDrawing = ((STATE == ST_CLEAR) || (STATE == ST_DRAW)) && (cntQ == N_C);
        if ((STATE == ST_SHOT) || (animQ == ANIM_FALL)) begin
            flying = (birdYQ < Y_FLOOR);
        end else if ((STATE == ST_ESCAPE) || (animQ == ANIM_RISE)) begin
            flying = (birdYQ != 7'd0);
        end else begin
            flying = 1'b0;
        end
    end

    assign x_out  = xOutQ;
    assign y_out  = yOutQ;
    assign colour = colourQ;
    assign plot   = plotQ;
    assign bird_x = birdXQ;
    assign bird_y = birdYQ;

endmodule

// File: tb/tb_bird_datapath.sv
// Directed bench for bird_datapath in its default build (solid DRAW colour).
// Walks reset, a CLEAR sweep, CLEAR->DRAW, saturating moves, the SHOT fall,
// the ESCAPE rise and an asynchronous reset in the middle of a DRAW sweep.
module tb_bird_datapath;
    import bird_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] STATE;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       plot;
    logic       doneDrawing;
    logic       flying;
    logic [7:0] bird_x;
    logic [6:0] bird_y;

    int total = 0;
    int bad   = 0;

    bird_datapath dut (
        .clk         (clk),
        .reset       (reset),
        .STATE       (STATE),
        .x_out       (x_out),
        .y_out       (y_out),
        .colour      (colour),
        .plot        (plot),
        .doneDrawing (doneDrawing),
        .flying      (flying),
        .bird_x      (bird_x),
        .bird_y      (bird_y)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts and reports it
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Present a state code to the datapath
    task automatic applyStimulus(input logic [3:0] s);
        STATE = s;
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect the 64-pixel sweep at (bx,by) in the given colour, starting the
    // edge after the state was applied
    task automatic checkSweep(input string tag, input int bx, input int by,
                              input int col);
        tick();
        checkOutput({tag, "_first_plot"}, plot, 0);
        checkOutput({tag, "_first_done"}, doneDrawing, 0);
        for (int k = 0; k < 64; k++) begin
            tick();
            checkOutput({tag, "_plot"}, plot, 1);
            checkOutput({tag, "_x"}, x_out, bx + (k % 8));
            checkOutput({tag, "_y"}, y_out, by + (k / 8));
            checkOutput({tag, "_colour"}, colour, col);
            checkOutput({tag, "_done"}, doneDrawing, (k == 63) ? 1 : 0);
        end
        tick();
        checkOutput({tag, "_no65_plot"}, plot, 0);
        checkOutput({tag, "_done_hold"}, doneDrawing, 1);
        tick();
        checkOutput({tag, "_still_no_plot"}, plot, 0);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(ST_HOLD);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_x_out", x_out, 0);
        checkOutput("rst_y_out", y_out, 0);
        checkOutput("rst_colour", colour, 0);
        checkOutput("rst_plot", plot, 0);
        checkOutput("rst_bird_x", bird_x, 76);
        checkOutput("rst_bird_y", bird_y, 100);
        checkOutput("rst_done", doneDrawing, 0);
        checkOutput("rst_flying", flying, 0);
        reset = 1'b0;

        $display("[TB] CLEAR sweep from spawn");
        applyStimulus(ST_CLEAR);
        checkSweep("clr", 76, 100, 3);

        $display("[TB] CLEAR straight into DRAW");
        applyStimulus(ST_DRAW);
        checkSweep("drw", 76, 100, 6);

        $display("[TB] saturating moves");
        applyStimulus(ST_UP_RIGHT);
        repeat (75) tick();
        checkOutput("ur_x151", bird_x, 151);
        checkOutput("ur_y25", bird_y, 25);
        checkOutput("ur_no_plot", plot, 0);
        tick();
        checkOutput("ur_x152", bird_x, 152);
        checkOutput("ur_y24", bird_y, 24);
        tick();
        checkOutput("ur_x_sat", bird_x, 152);
        checkOutput("ur_y23", bird_y, 23);
        applyStimulus(ST_UP_LEFT);
        repeat (23) tick();
        checkOutput("ul_y0", bird_y, 0);
        checkOutput("ul_x129", bird_x, 129);
        tick();
        checkOutput("ul_y_sat", bird_y, 0);
        checkOutput("ul_x128", bird_x, 128);
        applyStimulus(ST_DOWN_LEFT);
        tick();
        checkOutput("dl_x127", bird_x, 127);
        checkOutput("dl_y1", bird_y, 1);
        applyStimulus(4'hF);
        tick();
        checkOutput("bad_code_x", bird_x, 127);
        checkOutput("bad_code_y", bird_y, 1);
        checkOutput("bad_code_plot", plot, 0);

        $display("[TB] SHOT fall and NEW respawn");
        applyStimulus(ST_NEW);
        tick();
        checkOutput("new_x", bird_x, 76);
        checkOutput("new_y", bird_y, 100);
        applyStimulus(ST_SHOT);
        #1 checkOutput("shot1_flying", flying, 1);
        tick();
        checkOutput("shot1_y", bird_y, 104);
        applyStimulus(ST_HOLD);
        #1 checkOutput("fall_hold_flying", flying, 1);
        tick();
        applyStimulus(ST_SHOT);
        #1 checkOutput("shot2_flying", flying, 1);
        tick();
        checkOutput("shot2_y", bird_y, 108);
        checkOutput("shot3_flying", flying, 1);
        tick();
        checkOutput("shot3_y", bird_y, 112);
        checkOutput("shot_floor_flying", flying, 0);
        tick();
        checkOutput("shot_floor_y", bird_y, 112);
        applyStimulus(ST_NEW);
        tick();
        checkOutput("respawn_x", bird_x, 76);
        checkOutput("respawn_y", bird_y, 100);
        applyStimulus(ST_HOLD);
        #1 checkOutput("respawn_anim_none", flying, 0);

        $display("[TB] ESCAPE rise");
        applyStimulus(ST_UP_RIGHT);
        repeat (94) tick();
        checkOutput("pre_esc_y", bird_y, 6);
        checkOutput("pre_esc_x", bird_x, 152);
        applyStimulus(ST_ESCAPE);
        #1 checkOutput("esc1_flying", flying, 1);
        tick();
        checkOutput("esc1_y", bird_y, 2);
        checkOutput("esc2_flying", flying, 1);
        tick();
        checkOutput("esc2_y", bird_y, 0);
        checkOutput("esc3_flying", flying, 0);
        tick();
        checkOutput("esc3_y", bird_y, 0);
        applyStimulus(ST_DOWN_RIGHT);
        repeat (2) tick();
        checkOutput("rise_y2", bird_y, 2);
        applyStimulus(ST_CLEAR);
        #1 checkOutput("rise_clear_flying", flying, 1);
        tick();

        $display("[TB] async reset mid DRAW");
        applyStimulus(ST_NEW);
        tick();
        applyStimulus(ST_DOWN_RIGHT);
        repeat (3) tick();
        checkOutput("pre_drw_x", bird_x, 79);
        checkOutput("pre_drw_y", bird_y, 103);
        applyStimulus(ST_DRAW);
        repeat (31) tick();
        checkOutput("px29_plot", plot, 1);
        checkOutput("px29_x", x_out, 84);
        checkOutput("px29_y", y_out, 106);
        reset = 1'b1;
        #1;
        checkOutput("arst_plot", plot, 0);
        checkOutput("arst_bird_x", bird_x, 76);
        checkOutput("arst_bird_y", bird_y, 100);
        checkOutput("arst_x_out", x_out, 0);
        tick();
        reset = 1'b0;
        applyStimulus(ST_HOLD);
        tick();
        checkOutput("post_rst_plot", plot, 0);
        checkOutput("post_rst_x", bird_x, 76);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
